// File: rtl/node_tik_scheduler.sv
// Per-timestep neuron sweep sequencer: waits for a quiet input path, then strobes sd and soma.
// Optional stall counter when NODE_SCHED_PERF_EN is defined.
module node_tik_scheduler #(
  parameter int unsigned NNW    = 12,
  parameter int unsigned SD_LAT = 2,
  parameter int unsigned SCW    = 16
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           tik_i,
  input  logic           enable_i,
  input  logic [NNW-1:0] neu_num_i,
  input  logic           axon_busy_i,
  input  logic           spk_in_empty_i,
  input  logic           spk_out_afull_i,
  output logic           sd_vld_o,
  output logic           sd_clear_o,
  output logic [NNW-1:0] sd_vm_addr_o,
  output logic           soma_vld_o,
  output logic [NNW-1:0] soma_vm_addr_o,
  output logic           busy_o,
  output logic           done_o,
  output logic           overrun_o,
  output logic [SCW-1:0] stall_cnt_o
);

  typedef enum logic [2:0] {StIdle, StWait, StSweep, StDrain, StDone} state_e;

  state_e         state_q, state_d;
  logic [NNW-1:0] idx_q, idx_d;
  logic [NNW-1:0] n_lat_q, n_lat_d;
  logic           pending_q, pending_d;

  // Stage 0 drives sd, stage SD_LAT drives soma.
  logic [SD_LAT:0] vld_q, vld_d;
  logic [NNW-1:0]  addr_q [SD_LAT+1];
  logic [NNW-1:0]  addr_d [SD_LAT+1];

  logic busy_q, busy_d;
  logic done_q, done_d;
  logic overrun_q, overrun_d;

  logic inputs_quiet;
  logic issue;
  logic last_issue;
  logic pipe_empty;

  assign inputs_quiet = !axon_busy_i && spk_in_empty_i;
  assign issue        = (state_q == StSweep) && !spk_out_afull_i;
  assign last_issue   = issue && (idx_q == n_lat_q - NNW'(1));
  // Everything still in flight except the strobe currently presented to soma.
  assign pipe_empty   = (vld_q[SD_LAT-1:0] == '0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    n_lat_d   = n_lat_q;
    pending_d = pending_q;
    if (tik_i && (state_q != StIdle)) begin
      pending_d = 1'b1;
    end
    unique case (state_q)
      StIdle: begin
        if ((tik_i && enable_i) || pending_q) begin
          state_d   = StWait;
          n_lat_d   = neu_num_i;
          pending_d = 1'b0;
        end
      end
      StWait: begin
        if (inputs_quiet) begin
          state_d = (n_lat_q == '0) ? StDone : StSweep;
        end
      end
      StSweep: begin
        if (last_issue) begin
          state_d = StDrain;
          idx_d   = '0;
        end else if (issue) begin
          idx_d = idx_q + NNW'(1);
        end
      end
      StDrain: begin
        if (pipe_empty) begin
          state_d = StDone;
        end
      end
      StDone: begin
        if (pending_q) begin
          // The queued tik is consumed here; a tik in this same cycle becomes the new one.
          state_d   = StWait;
          n_lat_d   = neu_num_i;
          pending_d = tik_i;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    vld_d     = {vld_q[SD_LAT-1:0], issue};
    addr_d[0] = issue ? idx_q : '0;
    for (int unsigned i = 1; i <= SD_LAT; i++) begin
      addr_d[i] = addr_q[i-1];
    end
    busy_d    = (state_d != StIdle) || (vld_d != '0);
    done_d    = (state_d == StDone);
    overrun_d = tik_i && (state_q != StIdle);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      idx_q     <= '0;
      n_lat_q   <= '0;
      pending_q <= 1'b0;
      vld_q     <= '0;
      for (int unsigned i = 0; i <= SD_LAT; i++) begin
        addr_q[i] <= '0;
      end
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      idx_q     <= idx_d;
      n_lat_q   <= n_lat_d;
      pending_q <= pending_d;
      vld_q     <= vld_d;
      for (int unsigned i = 0; i <= SD_LAT; i++) begin
        addr_q[i] <= addr_d[i];
      end
      busy_q    <= busy_d;
      done_q    <= done_d;
      overrun_q <= overrun_d;
    end
  end

  assign sd_vld_o       = vld_q[0];
  assign sd_clear_o     = vld_q[0];
  assign sd_vm_addr_o   = addr_q[0];
  assign soma_vld_o     = vld_q[SD_LAT];
  assign soma_vm_addr_o = addr_q[SD_LAT];
  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign overrun_o      = overrun_q;

`ifdef NODE_SCHED_PERF_EN
  logic [SCW-1:0] stall_cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_cnt_q <= '0;
    end else if ((state_q == StSweep) && spk_out_afull_i && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + SCW'(1);
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`else
  assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_node_tik_scheduler.sv
// Bench for node_tik_scheduler: vector table of sweeps plus hand sequences, address scoreboard.
module tb_node_tik_scheduler;
  localparam int NNW    = 12;
  localparam int SD_LAT = 2;
  localparam int SCW    = 16;

  logic           clk_i = 1'b0;
  logic           rst_ni;
  logic           tik_i;
  logic           enable_i;
  logic [NNW-1:0] neu_num_i;
  logic           axon_busy_i;
  logic           spk_in_empty_i;
  logic           spk_out_afull_i;
  logic           sd_vld_o;
  logic           sd_clear_o;
  logic [NNW-1:0] sd_vm_addr_o;
  logic           soma_vld_o;
  logic [NNW-1:0] soma_vm_addr_o;
  logic           busy_o;
  logic           done_o;
  logic           overrun_o;
  logic [SCW-1:0] stall_cnt_o;

  always #5 clk_i = ~clk_i;

  node_tik_scheduler #(
    .NNW   (NNW),
    .SD_LAT(SD_LAT),
    .SCW   (SCW)
  ) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .tik_i          (tik_i),
    .enable_i       (enable_i),
    .neu_num_i      (neu_num_i),
    .axon_busy_i    (axon_busy_i),
    .spk_in_empty_i (spk_in_empty_i),
    .spk_out_afull_i(spk_out_afull_i),
    .sd_vld_o       (sd_vld_o),
    .sd_clear_o     (sd_clear_o),
    .sd_vm_addr_o   (sd_vm_addr_o),
    .soma_vld_o     (soma_vld_o),
    .soma_vm_addr_o (soma_vm_addr_o),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .overrun_o      (overrun_o),
    .stall_cnt_o    (stall_cnt_o)
  );

  // n, axon busy cycles after tik, stalled address, stall length, then expected edge offsets
  // (relative to the tik edge) of first sd strobe, first soma strobe, last done, busy low.
  typedef struct {
    int n;
    int bsy;
    int st_at;
    int st_len;
    int e_sd;
    int e_soma;
    int e_done;
    int e_blow;
  } vec_t;

  vec_t vecs[8];

  int checks = 0;
  int errors = 0;
  int k, first_sd, first_soma, first_done, done_k, busy_low;
  int sd_cnt, done_cnt, ov_cnt, stall_exp;
  logic [NNW-1:0] sd_q[$];
  logic [NNW-1:0] soma_q[$];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (k=%0d, t=%0t)", name, act, exp, k, $time);
    end
  endtask

  task automatic clear_records();
    first_sd   = -1;
    first_soma = -1;
    first_done = -1;
    done_k     = -1;
    busy_low   = -1;
    sd_cnt     = 0;
    done_cnt   = 0;
    ov_cnt     = 0;
  endtask

  task automatic sample();
    logic [NNW-1:0] e;
    check("sd_clear", int'(sd_clear_o), sd_vld_o ? 1 : 0);
    if (sd_vld_o) begin
      sd_cnt++;
      if (first_sd < 0) first_sd = k;
      if (sd_q.size() == 0) begin
        check("sd_unexpected", int'(sd_vm_addr_o), -1);
      end else begin
        e = sd_q.pop_front();
        check("sd_addr", int'(sd_vm_addr_o), int'(e));
      end
    end
    if (soma_vld_o) begin
      if (first_soma < 0) first_soma = k;
      if (soma_q.size() == 0) begin
        check("soma_unexpected", int'(soma_vm_addr_o), -1);
      end else begin
        e = soma_q.pop_front();
        check("soma_addr", int'(soma_vm_addr_o), int'(e));
      end
    end
    if (done_o) begin
      done_cnt++;
      done_k = k;
      if (first_done < 0) first_done = k;
    end
    if (overrun_o) ov_cnt++;
    if (!busy_o && busy_low < 0) busy_low = k;
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
    k++;
    sample();
  endtask

  task automatic launch(input int n);
    neu_num_i = NNW'(n);
    tik_i     = 1'b1;
    @(posedge clk_i);
    #1;
    tik_i = 1'b0;
    k     = 0;
    clear_records();
    sample();
  endtask

  task automatic push_sweep(input int n);
    for (int a = 0; a < n; a++) begin
      sd_q.push_back(NNW'(a));
      soma_q.push_back(NNW'(a));
    end
  endtask

  task automatic check_stall();
`ifdef NODE_SCHED_PERF_EN
    check("stall_cnt", int'(stall_cnt_o), stall_exp);
`else
    check("stall_cnt", int'(stall_cnt_o), 0);
`endif
  endtask

  task automatic run_vec(input vec_t v);
    int base;
    base = 2 + v.bsy + v.st_at;
    push_sweep(v.n);
    enable_i        = 1'b1;
    axon_busy_i     = 1'b0;
    spk_out_afull_i = 1'b0;
    launch(v.n);
    for (int j = 0; j < 6000 && busy_low < 0; j++) begin
      axon_busy_i     = (k + 1 <= v.bsy);
      spk_out_afull_i = (k + 1 >= base) && (k + 1 < base + v.st_len);
      step();
    end
    axon_busy_i     = 1'b0;
    spk_out_afull_i = 1'b0;
    if (busy_low < 0) check("vec_timeout", 0, 1);
    stall_exp += v.st_len;
    check("first_sd", first_sd, v.e_sd);
    check("first_soma", first_soma, v.e_soma);
    check("done_at", done_k, v.e_done);
    check("busy_low_at", busy_low, v.e_blow);
    check("sd_count", sd_cnt, v.n);
    check("done_count", done_cnt, 1);
    check("overrun_count", ov_cnt, 0);
    check("sd_q_left", sd_q.size(), 0);
    check("soma_q_left", soma_q.size(), 0);
    check_stall();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_sd_vld"}, int'(sd_vld_o), 0);
    check({tag, "_sd_addr"}, int'(sd_vm_addr_o), 0);
    check({tag, "_soma_vld"}, int'(soma_vld_o), 0);
    check({tag, "_soma_addr"}, int'(soma_vm_addr_o), 0);
    check({tag, "_busy"}, int'(busy_o), 0);
    check({tag, "_done"}, int'(done_o), 0);
    check({tag, "_overrun"}, int'(overrun_o), 0);
    check({tag, "_stall"}, int'(stall_cnt_o), 0);
  endtask

  initial begin
    vecs[0] = '{n: 4,    bsy: 0, st_at: 0, st_len: 0, e_sd: 2,  e_soma: 4,  e_done: 8,    e_blow: 9};
    vecs[1] = '{n: 4,    bsy: 5, st_at: 0, st_len: 0, e_sd: 7,  e_soma: 9,  e_done: 13,   e_blow: 14};
    vecs[2] = '{n: 4,    bsy: 0, st_at: 2, st_len: 3, e_sd: 2,  e_soma: 4,  e_done: 11,   e_blow: 12};
    vecs[3] = '{n: 0,    bsy: 0, st_at: 0, st_len: 0, e_sd: -1, e_soma: -1, e_done: 1,    e_blow: 2};
    vecs[4] = '{n: 1,    bsy: 0, st_at: 0, st_len: 0, e_sd: 2,  e_soma: 4,  e_done: 5,    e_blow: 6};
    vecs[5] = '{n: 0,    bsy: 3, st_at: 0, st_len: 0, e_sd: -1, e_soma: -1, e_done: 4,    e_blow: 5};
    vecs[6] = '{n: 4095, bsy: 0, st_at: 0, st_len: 0, e_sd: 2,  e_soma: 4,  e_done: 4099, e_blow: 4100};
    vecs[7] = '{n: 3,    bsy: 2, st_at: 0, st_len: 2, e_sd: 6,  e_soma: 8,  e_done: 11,   e_blow: 12};

    rst_ni          = 1'b0;
    tik_i           = 1'b0;
    enable_i        = 1'b0;
    neu_num_i       = '0;
    axon_busy_i     = 1'b0;
    spk_in_empty_i  = 1'b1;
    spk_out_afull_i = 1'b0;
    k               = 0;
    stall_exp       = 0;
    clear_records();

    repeat (3) @(posedge clk_i);
    #1;
    check_all_zero("reset");
    @(negedge clk_i);
    rst_ni = 1'b1;
    step();
    check("post_release_sd_vld", int'(sd_vld_o), 0);

    foreach (vecs[i]) run_vec(vecs[i]);

    // Two tiks mid-sweep with enable dropped and neu_num changed after the latch.
    push_sweep(4);
    push_sweep(2);
    enable_i = 1'b1;
    launch(4);
    enable_i  = 1'b0;
    neu_num_i = NNW'(2);
    for (int j = 0; j < 200 && busy_low < 0; j++) begin
      tik_i = (k + 1 == 3) || (k + 1 == 5);
      step();
    end
    tik_i = 1'b0;
    if (busy_low < 0) check("ovr_timeout", 0, 1);
    check("ovr_overrun_count", ov_cnt, 2);
    check("ovr_first_done", first_done, 8);
    check("ovr_last_done", done_k, 15);
    check("ovr_done_count", done_cnt, 2);
    check("ovr_sd_count", sd_cnt, 6);
    check("ovr_busy_low", busy_low, 16);
    check("ovr_sd_q_left", sd_q.size(), 0);

    // tik while disabled in IDLE is ignored.
    enable_i = 1'b0;
    launch(4);
    repeat (4) step();
    check("dis_overrun", ov_cnt, 0);
    check("dis_sd_count", sd_cnt, 0);
    check("dis_done_count", done_cnt, 0);
    check("dis_busy_low", busy_low, 0);

    // Asynchronous reset in the middle of a sweep.
    enable_i = 1'b1;
    push_sweep(4);
    launch(4);
    repeat (3) step();
    check("rst_pre_addr", int'(sd_vm_addr_o), 1);
    #2;
    rst_ni = 1'b0;
    #1;
    check_all_zero("midrst");
    sd_q.delete();
    soma_q.delete();
    stall_exp = 0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
    run_vec('{n: 3, bsy: 0, st_at: 0, st_len: 0, e_sd: 2, e_soma: 4, e_done: 7, e_blow: 8});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
